// File: rtl/cv32e40p_breakage_monitor_mc.sv
// Multi-channel breakage monitor for triplicated pipeline sub-blocks.
// Per channel: saturating leaky-bucket error counter plus a health FSM.
module cv32e40p_breakage_monitor_mc #(
  parameter int N_CH               = 6,
  parameter int COUNT_BIT          = 8,
  parameter int INC_DEC_BIT        = 2,
  parameter int INCREMENT          = 1,
  parameter int DECREMENT          = 1,
  parameter int BREAKING_THRESHOLD = 3,
  parameter int DECAY_PERIOD       = 4,
  parameter int STICKY             = 1,
  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      valid_i,
  input  logic [N_CH-1:0]      err_i,
  input  logic [N_CH-1:0]      clear_i,
  output logic [N_CH-1:0]      broken_o,
  output logic [N_CH-1:0]      suspect_o,
  output logic [N_CH-1:0]      broken_event_o,
  output logic                 any_broken_o,
  input  logic [SW-1:0]        sel_i,
  output logic [COUNT_BIT-1:0] count_o
);

  localparam int TW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam int CW = COUNT_BIT + 1;

  if (INCREMENT < 1 || INCREMENT >= (1 << INC_DEC_BIT)) begin : g_bad_inc
    $error("INCREMENT out of range");
  end
  if (DECREMENT < 1 || DECREMENT >= (1 << INC_DEC_BIT)) begin : g_bad_dec
    $error("DECREMENT out of range");
  end
  if (BREAKING_THRESHOLD > (1 << COUNT_BIT) - 1) begin : g_bad_th
    $error("BREAKING_THRESHOLD out of range");
  end
  if (DECAY_PERIOD < 1) begin : g_bad_dp
    $error("DECAY_PERIOD must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_OK,
    ST_SUSPECT,
    ST_BROKEN
  } state_e;

  logic [COUNT_BIT-1:0] cnt_q [N_CH];
  logic [COUNT_BIT-1:0] cnt_d [N_CH];
  logic [TW-1:0]        tmr_q [N_CH];
  logic [TW-1:0]        tmr_d [N_CH];
  state_e               st_q  [N_CH];
  state_e               st_d  [N_CH];
  logic [N_CH-1:0]      ev_q;
  logic [N_CH-1:0]      ev_d;

  // Next counter, decay timer, state and entry pulse for every channel
  always_comb begin
    logic [CW-1:0] inc_w;
    logic [CW-1:0] dec_w;
    logic          frozen;
    inc_w  = '0;
    dec_w  = '0;
    frozen = 1'b0;
    ev_d   = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      tmr_d[i] = tmr_q[i];
      st_d[i]  = st_q[i];
      inc_w    = {1'b0, cnt_q[i]} + CW'(INCREMENT);
      dec_w    = {1'b0, cnt_q[i]} - CW'(DECREMENT);
      frozen   = (STICKY != 0) && (st_q[i] == ST_BROKEN);
      if (clear_i[i]) begin
        cnt_d[i] = '0;
        tmr_d[i] = '0;
        st_d[i]  = ST_OK;
      end else if (!frozen) begin
        if (valid_i[i] && err_i[i]) begin
          cnt_d[i] = inc_w[COUNT_BIT] ? '1 : inc_w[COUNT_BIT-1:0];
          tmr_d[i] = '0;
        end else if (valid_i[i]) begin
          if (tmr_q[i] == TW'(DECAY_PERIOD - 1)) begin
            cnt_d[i] = dec_w[COUNT_BIT] ? '0 : dec_w[COUNT_BIT-1:0];
            tmr_d[i] = '0;
          end else begin
            tmr_d[i] = tmr_q[i] + TW'(1);
          end
        end
        // BROKEN only leaves through a zero count (hysteresis)
        if (cnt_d[i] == '0) begin
          st_d[i] = ST_OK;
        end else if (st_q[i] == ST_BROKEN) begin
          st_d[i] = ST_BROKEN;
        end else if (cnt_d[i] >= COUNT_BIT'(BREAKING_THRESHOLD)) begin
          st_d[i] = ST_BROKEN;
        end else begin
          st_d[i] = ST_SUSPECT;
        end
      end
      ev_d[i] = (st_d[i] == ST_BROKEN) && (st_q[i] != ST_BROKEN);
    end
  end

  // Per-channel state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
        tmr_q[i] <= '0;
        st_q[i]  <= ST_OK;
      end
      ev_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        tmr_q[i] <= tmr_d[i];
        st_q[i]  <= st_d[i];
      end
      ev_q <= ev_d;
    end
  end

  // State decode and count readout mux
  always_comb begin
    broken_o  = '0;
    suspect_o = '0;
    count_o   = '0;
    for (int i = 0; i < N_CH; i++) begin
      broken_o[i]  = (st_q[i] == ST_BROKEN);
      suspect_o[i] = (st_q[i] == ST_SUSPECT);
      if (sel_i == SW'(i)) begin
        count_o = cnt_q[i];
      end
    end
  end

  assign broken_event_o = ev_q;
  assign any_broken_o   = |broken_o;

endmodule

// File: doc/cv32e40p_breakage_monitor_mc.md
Name: cv32e40p_breakage_monitor_mc

Overview:
Multi-channel breakage monitor for the fault-tolerant (triplicated) pipeline sub-blocks. Each channel takes the voter-mismatch flag of one protected sub-block (program counter, prefetch buffer, aligner, compressed decoder, ...). Each channel keeps a saturating leaky-bucket error counter and a 3-state health FSM, and flags the sub-block as broken once the error count crosses a threshold. It generalises the single-module monitor with these additions: a channel count, a configurable decay period, a sticky or recoverable mode, per-channel clear, breakage event pulses and a count readout.

Parameters:
N_CH, 6, number of monitored channels (>=1)
COUNT_BIT, 8, error counter width per channel
INC_DEC_BIT, 2, width of increment/decrement step values
INCREMENT, 1, counter step on an error sample (1 .. 2^INC_DEC_BIT-1)
DECREMENT, 1, counter step on a decay tick (1 .. 2^INC_DEC_BIT-1)
BREAKING_THRESHOLD, 3, count at or above which a channel is BROKEN (1 .. 2^COUNT_BIT-1)
DECAY_PERIOD, 4, clean valid samples per decrement (>=1)
STICKY, 1, 1 = BROKEN exits only via clear/reset; 0 = BROKEN recovers when count returns to 0

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
valid_i  in  N_CH  per-channel sample qualifier; err_i is ignored when low
err_i  in  N_CH  per-channel voter mismatch flag
clear_i  in  N_CH  per-channel synchronous clear of the counter, decay timer and FSM
broken_o  out  N_CH  per-channel BROKEN state
suspect_o  out  N_CH  per-channel SUSPECT state
broken_event_o  out  N_CH  one-cycle pulse on entry to BROKEN
any_broken_o  out  1  OR of broken_o
sel_i  in  clog2(N_CH) (min 1)  readout channel select
count_o  out  COUNT_BIT  counter of the channel selected by sel_i (combinational mux of registers)

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state:
  - all counters 0, decay timers 0, all FSMs in OK
  - broken_o, suspect_o, broken_event_o, any_broken_o = 0
  - count_o = 0
- Per-channel update on each rising clk edge. Priority: clear_i > frozen > valid_i&err_i > valid_i&!err_i > hold.
  - clear_i=1: count 0, timer 0, state OK, no event pulse.
  - STICKY=1 and state BROKEN: count and timer frozen.
  - valid_i&err_i: count = min(count+INCREMENT, 2^COUNT_BIT-1); timer 0.
  - valid_i&!err_i: if timer==DECAY_PERIOD-1 then count = max(count-DECREMENT, 0) and timer 0, else timer+1. DECAY_PERIOD=1 decrements on every clean sample.
  - valid_i=0: count and timer hold.
- Arithmetic: widen by one bit before saturation; count never wraps.
- Next state is computed from the next count:
  - OK when count 0
  - SUSPECT when 0 < count < BREAKING_THRESHOLD
  - BROKEN when count >= BREAKING_THRESHOLD
  - STICKY=0: BROKEN stays BROKEN until count reaches 0 (hysteresis), then goes to OK. SUSPECT is never re-entered from BROKEN.
- Latency: broken_o/suspect_o are registered and change on the same edge that samples err_i. There is no added latency beyond that one edge.
- broken_event_o[i] = 1 for exactly the one cycle after a transition into BROKEN. Re-entry after a clear or recovery produces a new pulse.
- Channels are fully independent. Simultaneous events on different channels are all processed in the same cycle.
- sel_i >= N_CH: count_o = 0.
- Reset asserted mid-operation clears all state immediately, with no clock needed. A pulse in flight on broken_event_o is dropped.
- Elaboration error if INCREMENT or DECREMENT is 0 or >= 2^INC_DEC_BIT, if BREAKING_THRESHOLD > 2^COUNT_BIT-1, or if DECAY_PERIOD < 1.

Test Plan:
1. Defaults. Drive valid_i[2]=err_i[2]=1 for 3 cycles.
   -> count 1, 2, 3
   -> suspect_o[2] after edge 1
   -> broken_o[2] and any_broken_o after edge 3
   -> broken_event_o[2] high for exactly 1 cycle
   -> further clean samples leave count at 3 (sticky)
2. Defaults. Drive 2 error samples on ch0, then 8 clean valid samples.
   -> count 2, then 1 after the 4th clean sample, then 0 after the 8th
   -> suspect_o[0] drops, broken_o[0] never asserts
   -> with valid_i low in between, count and timer hold
3. STICKY=0, COUNT_BIT=8, DECAY_PERIOD=1. Drive 300 error samples on ch1.
   -> count saturates at 255, no wrap
   -> then 255 clean samples return count to 0; broken_o[1] stays high until count is 0, then OK with no event pulse
4. ch3 at count 3 (BROKEN). Assert clear_i[3] and err_i[3] in the same cycle.
   -> count 0, OK, broken_o[3]=0
   -> the following 3 errors raise a second broken_event_o[3] pulse
5. Errors on ch0 and ch5 simultaneously for 3 cycles, with sel_i=5.
   -> both channels go BROKEN on the same edge with two event bits set
   -> count_o=3
   -> sel_i=7 gives count_o=0
6. Assert rst asynchronously between clock edges while ch4 is at count 2.
   -> all outputs 0 immediately
   -> after release, count restarts from 0
